// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage IEEE-754 FLE/FLT/FEQ compare unit with a
// valid/ready handshake and an opaque tag carried alongside each operation.
// Optional FMIN/FMAX support is enabled by defining FP_COMPARE_MINMAX_EN.
module fp_compare_pipe #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic                 out_nv,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int unsigned MAN_W = BUS_WIDTH - 1 - EXP_W;
    localparam int unsigned MAG_W = BUS_WIDTH - 1;

    localparam logic [2:0] OP_FLE  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
`ifdef FP_COMPARE_MINMAX_EN
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;
    localparam logic [BUS_WIDTH-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

    // Flow control
    logic w_s1_adv;
    logic w_s2_adv;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_nan_a, r_s1_nan_b;
    logic             r_s1_snan_a, r_s1_snan_b;
    logic             r_s1_zero_a, r_s1_zero_b;
    logic             r_s1_sign_a, r_s1_sign_b;
    logic             r_s1_a_mag_lt;
    logic             r_s1_mag_eq;
`ifdef FP_COMPARE_MINMAX_EN
    logic [BUS_WIDTH-1:0] r_s1_a, r_s1_b;
`endif

    // Stage 2 registers
    logic                 r_s2_valid;
    logic [BUS_WIDTH-1:0] r_s2_result;
    logic                 r_s2_nv;
    logic [TAG_W-1:0]     r_s2_tag;

    // Operand pre-decode
    logic [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [MAN_W-1:0] w_man_a, w_man_b;
    logic             w_nan_a, w_nan_b;
    logic             w_snan_a, w_snan_b;
    logic             w_zero_a, w_zero_b;
    logic             w_a_mag_lt, w_mag_eq;

    // Stage 2 combinational result
    logic                 w_any_nan;
    logic                 w_any_snan;
    logic                 w_eq;
    logic                 w_lt;
    logic [BUS_WIDTH-1:0] w_result;
    logic                 w_nv;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_nv     = r_s2_nv;
    assign out_tag    = r_s2_tag;

    // Classify both operands and compare their magnitudes ({exp,mant})
    always_comb begin
        w_exp_a    = in_a[MAG_W-1 -: EXP_W];
        w_exp_b    = in_b[MAG_W-1 -: EXP_W];
        w_man_a    = in_a[MAN_W-1:0];
        w_man_b    = in_b[MAN_W-1:0];
        w_nan_a    = (&w_exp_a) & (|w_man_a);
        w_nan_b    = (&w_exp_b) & (|w_man_b);
        w_snan_a   = w_nan_a & ~w_man_a[MAN_W-1];
        w_snan_b   = w_nan_b & ~w_man_b[MAN_W-1];
        w_zero_a   = ~(|in_a[MAG_W-1:0]);
        w_zero_b   = ~(|in_b[MAG_W-1:0]);
        w_a_mag_lt = in_a[MAG_W-1:0] < in_b[MAG_W-1:0];
        w_mag_eq   = in_a[MAG_W-1:0] == in_b[MAG_W-1:0];
    end

    // Stage 1: capture op, tag and decoded operand classes on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= 3'b000;
            r_s1_tag      <= '0;
            r_s1_nan_a    <= 1'b0;
            r_s1_nan_b    <= 1'b0;
            r_s1_snan_a   <= 1'b0;
            r_s1_snan_b   <= 1'b0;
            r_s1_zero_a   <= 1'b0;
            r_s1_zero_b   <= 1'b0;
            r_s1_sign_a   <= 1'b0;
            r_s1_sign_b   <= 1'b0;
            r_s1_a_mag_lt <= 1'b0;
            r_s1_mag_eq   <= 1'b0;
`ifdef FP_COMPARE_MINMAX_EN
            r_s1_a        <= '0;
            r_s1_b        <= '0;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op       <= in_op;
                r_s1_tag      <= in_tag;
                r_s1_nan_a    <= w_nan_a;
                r_s1_nan_b    <= w_nan_b;
                r_s1_snan_a   <= w_snan_a;
                r_s1_snan_b   <= w_snan_b;
                r_s1_zero_a   <= w_zero_a;
                r_s1_zero_b   <= w_zero_b;
                r_s1_sign_a   <= in_a[BUS_WIDTH-1];
                r_s1_sign_b   <= in_b[BUS_WIDTH-1];
                r_s1_a_mag_lt <= w_a_mag_lt;
                r_s1_mag_eq   <= w_mag_eq;
`ifdef FP_COMPARE_MINMAX_EN
                r_s1_a        <= in_a;
                r_s1_b        <= in_b;
`endif
            end
        end
    end

    // Ordered equal / less-than from the stage-1 classes (NaNs handled later)
    always_comb begin
        w_any_nan  = r_s1_nan_a | r_s1_nan_b;
        w_any_snan = r_s1_snan_a | r_s1_snan_b;
        w_eq       = (r_s1_mag_eq & (r_s1_sign_a == r_s1_sign_b)) |
                     (r_s1_zero_a & r_s1_zero_b);
        if (r_s1_zero_a & r_s1_zero_b) begin
            w_lt = 1'b0;
        end else if (r_s1_sign_a != r_s1_sign_b) begin
            w_lt = r_s1_sign_a;
        end else if (!r_s1_sign_a) begin
            w_lt = r_s1_a_mag_lt;
        end else begin
            w_lt = ~r_s1_a_mag_lt & ~r_s1_mag_eq;
        end
    end

    // Per-op result and invalid flag; unknown ops produce 0 with nv clear
    always_comb begin
        w_result = '0;
        w_nv     = 1'b0;
        case (r_s1_op)
            OP_FLE: begin
                w_result = BUS_WIDTH'(~w_any_nan & (w_lt | w_eq));
                w_nv     = w_any_nan;
            end
            OP_FLT: begin
                w_result = BUS_WIDTH'(~w_any_nan & w_lt);
                w_nv     = w_any_nan;
            end
            OP_FEQ: begin
                w_result = BUS_WIDTH'(~w_any_nan & w_eq);
                w_nv     = w_any_snan;
            end
`ifdef FP_COMPARE_MINMAX_EN
            OP_FMIN, OP_FMAX: begin
                w_nv = w_any_snan;
                if (r_s1_nan_a & r_s1_nan_b) begin
                    w_result = CANON_NAN;
                end else if (r_s1_nan_a) begin
                    w_result = r_s1_b;
                end else if (r_s1_nan_b) begin
                    w_result = r_s1_a;
                end else if ((w_lt | (w_eq & r_s1_sign_a)) ^ (r_s1_op == OP_FMAX)) begin
                    // a is the minimum (negative zero wins ties for min)
                    w_result = r_s1_a;
                end else begin
                    w_result = r_s1_b;
                end
            end
`endif
            default: begin
                w_result = '0;
                w_nv     = 1'b0;
            end
        endcase
    end

    // Stage 2: register the final result, hold it while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_nv     <= 1'b0;
            r_s2_tag    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_result;
                r_s2_nv     <= w_nv;
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Testbench for fp_compare_pipe: 32-bit scoreboard-checked instance plus a
// small directed 64-bit instance.
module tb_fp_compare_pipe;

    localparam logic [2:0] FLE  = 3'b000;
    localparam logic [2:0] FLT  = 3'b001;
    localparam logic [2:0] FEQ  = 3'b010;
    localparam logic [2:0] FMIN = 3'b011;
    localparam logic [2:0] FMAX = 3'b100;
    localparam logic [2:0] RSVD = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_nv;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;

    logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_out_nv;
    logic [2:0]  v64_in_op;
    logic [63:0] v64_in_a, v64_in_b, v64_out_result;
    logic [4:0]  v64_in_tag, v64_out_tag;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    always #5 clk = ~clk;

    fp_compare_pipe #(.BUS_WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_nv(out_nv), .out_tag(out_tag)
    );

    fp_compare_pipe #(.BUS_WIDTH(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_op(v64_in_op),
        .in_a(v64_in_a), .in_b(v64_in_b), .in_tag(v64_in_tag),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready),
        .out_result(v64_out_result), .out_nv(v64_out_nv), .out_tag(v64_out_tag)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Present one op, wait (bounded) for acceptance and record its expected result
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] er, input logic en);
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.res = er;
            e.nv  = en;
            e.tag = tag;
            sb.push_back(e);
            n_push++;
            n_acc++;
        end else begin
            n_tests++;
            n_fail++;
            $error("FAIL accept_timeout: tag %0d observed not accepted expected accepted", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // 64-bit directed op: check acceptance, 2-cycle latency and outputs
    task automatic op64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic [63:0] er, input logic en);
        v64_in_valid = 1'b1;
        v64_in_op    = op;
        v64_in_a     = a;
        v64_in_b     = b;
        v64_in_tag   = tag;
        @(negedge clk);
        chk("d64_in_ready", v64_in_ready, 1);
        @(posedge clk);
        #1;
        v64_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("d64_out_valid", v64_out_valid, 1);
        chk("d64_result", v64_out_result, er);
        chk("d64_nv", v64_out_nv, en);
        chk("d64_tag", v64_out_tag, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Scoreboard monitor: compare every output transfer against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_output: observed tag %0d expected no output", out_tag);
            end else begin
                e = sb.pop_front();
                n_pop++;
                chk("result", out_result, e.res);
                chk("nv", out_nv, e.nv);
                chk("tag", out_tag, e.tag);
            end
        end
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_op         = 3'b000;
        in_a          = '0;
        in_b          = '0;
        in_tag        = '0;
        out_ready     = 1'b1;
        v64_in_valid  = 1'b0;
        v64_in_op     = 3'b000;
        v64_in_a      = '0;
        v64_in_b      = '0;
        v64_in_tag    = '0;
        v64_out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_nv", out_nv, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: output valid exactly two cycles after acceptance
        send(FLT, 32'h3F800000, 32'h40000000, 5'd7, 32'd1, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_cycle2", out_valid, 1);
        @(posedge clk);
        #1;

        // Back-to-back directed compares
        send(FLT, 32'hC0000000, 32'hBF800000, 5'd1, 32'd1, 1'b0);
        send(FLE, 32'h40000000, 32'h40000000, 5'd2, 32'd1, 1'b0);
        send(FEQ, 32'h00000000, 32'h80000000, 5'd3, 32'd1, 1'b0);
        send(FLE, 32'h00000000, 32'h80000000, 5'd4, 32'd1, 1'b0);
        send(FLT, 32'h00000000, 32'h80000000, 5'd5, 32'd0, 1'b0);
        send(FLT, 32'h80000000, 32'h00000000, 5'd6, 32'd0, 1'b0);
        send(FEQ, 32'h7FC00000, 32'h3F800000, 5'd8, 32'd0, 1'b0);
        send(FEQ, 32'h7F800001, 32'h3F800000, 5'd9, 32'd0, 1'b1);
        send(FLT, 32'h7FC00000, 32'h3F800000, 5'd10, 32'd0, 1'b1);
        send(FLE, 32'h3F800000, 32'h7FC00000, 5'd11, 32'd0, 1'b1);
        send(FLT, 32'hFF800000, 32'h3F800000, 5'd12, 32'd1, 1'b0);
        send(FLE, 32'h7F800000, 32'h7F7FFFFF, 5'd13, 32'd0, 1'b0);
        send(FEQ, 32'hFF800000, 32'hFF800000, 5'd14, 32'd1, 1'b0);
        send(FLT, 32'h3F800000, 32'h3F800000, 5'd15, 32'd0, 1'b0);
        send(FLE, 32'h3F800000, 32'hBF800000, 5'd16, 32'd0, 1'b0);
        send(RSVD, 32'h3F800000, 32'h40000000, 5'd17, 32'd0, 1'b0);
`ifdef FP_COMPARE_MINMAX_EN
        send(FMIN, 32'h7FC00000, 32'h3F800000, 5'd18, 32'h3F800000, 1'b0);
        send(FMIN, 32'h00000000, 32'h80000000, 5'd19, 32'h80000000, 1'b0);
        send(FMAX, 32'h7F800001, 32'h7FC00000, 5'd20, 32'h7FC00000, 1'b1);
        send(FMAX, 32'h80000000, 32'h00000000, 5'd21, 32'h00000000, 1'b0);
        send(FMIN, 32'hC0000000, 32'h3F800000, 5'd22, 32'hC0000000, 1'b0);
`else
        send(FMIN, 32'h7FC00000, 32'h3F800000, 5'd18, 32'd0, 1'b0);
        send(FMIN, 32'h00000000, 32'h80000000, 5'd19, 32'd0, 1'b0);
        send(FMAX, 32'h7F800001, 32'h7FC00000, 5'd20, 32'd0, 1'b0);
        send(FMAX, 32'h80000000, 32'h00000000, 5'd21, 32'd0, 1'b0);
        send(FMIN, 32'hC0000000, 32'h3F800000, 5'd22, 32'd0, 1'b0);
`endif
        drain();

        // Backpressure: four ops with the consumer stalled for three cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                send(FLT, 32'h3F800000, 32'h40000000, 5'd1, 32'd1, 1'b0);
                send(FLE, 32'h40000000, 32'h3F800000, 5'd2, 32'd0, 1'b0);
                send(FEQ, 32'h3F800000, 32'h3F800000, 5'd3, 32'd1, 1'b0);
                send(FLT, 32'hBF800000, 32'hC0000000, 5'd4, 32'd0, 1'b0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #2;
                    if (n_acc >= 2) break;
                end
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_head_tag", out_tag, 1);
                held_res = out_result;
                held_tag = out_tag;
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_stable_result", out_result, held_res);
                    chk("bp_stable_tag", out_tag, held_tag);
                    chk("bp_stall_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_no_dup", n_pop, n_push);

        // Reset with both stages occupied
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(FLT, 32'h3F800000, 32'h40000000, 5'd25, 32'd1, 1'b0);
        send(FEQ, 32'h3F800000, 32'h3F800000, 5'd26, 32'd1, 1'b0);
        @(negedge clk);
        chk("mid_full_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        n_push = n_pop;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(FEQ, 32'h3F800000, 32'h3F800000, 5'd27, 32'd1, 1'b0);
        @(negedge clk);
        chk("post_rst_lat1", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_lat2", out_valid, 1);
        drain();

        // Double precision
        @(posedge clk);
        #1;
        op64(FLE, 64'h7FF8000000000000, 64'h0, 5'd3, 64'd0, 1'b1);
        op64(FLT, 64'hFFF0000000000000, 64'h3FF0000000000000, 5'd4, 64'd1, 1'b0);
        op64(FEQ, 64'h7FF0000000000001, 64'h7FF0000000000001, 5'd5, 64'd0, 1'b1);
        op64(FEQ, 64'h8000000000000000, 64'h0, 5'd6, 64'd1, 1'b0);

        chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
